prv32_mdu_seq: RTL and testbench

Sequencer for the RV32M multiply/divide path of the prv32 core. It accepts one M-extension operation at a time from the execute stage over a valid/ready handshake. Multiplies complete in a single registered cycle. Divides and remainders run as an iterative 32-step restoring divider, and RISC-V divide special cases are resolved without iterating. The result is held with a destination tag until writeback accepts it, and a flush from the hazard unit aborts any operation in flight.

---
 rtl/prv32_mdu_seq.sv | 175 +++++++++++++++++
 tb/tb_prv32_mdu_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prv32_mdu_seq.sv
// rtl/prv32_mdu_seq.sv - RV32M multiply/divide sequencer with iterative restoring divider
module prv32_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [2:0]      op_q;
  // opa holds the multiplicand, or the dividend that shifts out into the quotient
  logic [XLEN-1:0] opa;
  // opb holds the multiplier, or the (absolute) divisor
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] rem_q;
  logic [4:0]      cnt;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            in_signed_div;
  logic            in_b_zero;
  logic            in_ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            step_ok;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] div_res;

  logic            a_sx;
  logic            b_sx;
  logic [2*XLEN-1:0] a_w;
  logic [2*XLEN-1:0] b_w;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && (state == S_IDLE) && !flush;

  // Accept-cycle decode: divide special cases and operand magnitudes
  always_comb begin
    in_signed_div = ~in_op[0];
    in_b_zero     = (in_b == '0);
    in_ovf        = in_signed_div && (in_a == MIN_NEG) && (in_b == ALL_ONES);
    abs_a         = (in_signed_div && in_a[XLEN-1]) ? (~in_a + 1'b1) : in_a;
    abs_b         = (in_signed_div && in_b[XLEN-1]) ? (~in_b + 1'b1) : in_b;
  end

  // One restoring-division step and the sign-corrected result of the final step
  always_comb begin
    rem_sh  = {rem_q, opa[XLEN-1]};
    diff    = rem_sh - {1'b0, opb};
    step_ok = ~diff[XLEN];
    rem_nx  = step_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {opa[XLEN-2:0], step_ok};
    if (op_q[1]) begin
      div_res = neg_r ? (~rem_nx + 1'b1) : rem_nx;
    end else begin
      div_res = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    end
  end

  // 64-bit product with per-op operand extension
  always_comb begin
    a_sx    = (op_q[1:0] != 2'b11) && opa[XLEN-1];
    b_sx    = (op_q[1] == 1'b0) && opb[XLEN-1];
    a_w     = {{XLEN{a_sx}}, opa};
    b_w     = {{XLEN{b_sx}}, opb};
    prod    = a_w * b_w;
    mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Sequencer FSM with registered result, tag and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      opa        <= '0;
      opb        <= '0;
      rem_q      <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= in_op;
            out_tag <= in_tag;
            cnt     <= '0;
            rem_q   <= '0;
            if (!in_op[2]) begin
              opa   <= in_a;
              opb   <= in_b;
              state <= S_MUL;
            end else if (in_b_zero) begin
              out_result <= in_op[1] ? in_a : ALL_ONES;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end else if (in_ovf) begin
              out_result <= in_op[1] ? '0 : MIN_NEG;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end else begin
              opa   <= abs_a;
              opb   <= abs_b;
              neg_q <= in_signed_div && (in_a[XLEN-1] ^ in_b[XLEN-1]);
              neg_r <= in_signed_div && in_a[XLEN-1];
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          out_result <= mul_res;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DIV: begin
          opa   <= quo_nx;
          rem_q <= rem_nx;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            out_result <= div_res;
            out_valid  <= 1'b1;
            cnt        <= '0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_mdu_seq.sv
// tb/tb_prv32_mdu_seq.sv - self-checking bench for prv32_mdu_seq against an arithmetic reference model
module tb_prv32_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  prv32_mdu_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics with plain 64-bit and 32-bit arithmetic
  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    int ia, ib;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; v = p; return v[31:0]; end
      3'd1: begin p = sa * sb; v = p; return v[63:32]; end
      3'd2: begin p = sa * longint'(ub); v = p; return v[63:32]; end
      3'd3: begin up = ua * ub; v = up; return v[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1;
    if (b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Issue one op, measure edges from accept to out_valid, check result/tag, optionally consume
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input bit consume);
    int n;
    logic [31:0] exp_res;
    exp_res = ref_calc(op, a, b);
    @(negedge clk);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_op    = 3'($urandom_range(0, 7));
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
      if (!out_valid) chk({name, "_busy_run"}, {31'd0, busy}, 32'd1);
    end
    chk({name, "_latency"}, n, ref_lat(op, a, b));
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          rose;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_tag    = 5'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    do_op("mulh_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, 5'd7, 1'b1);
    chk("mulh_const", out_result, 32'hFFFF_FFFF);
    do_op("mul_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 5'd8, 1'b1);
    chk("mul_const", out_result, 32'hFFFF_FFFA);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd1, 1'b1);
    chk("divu_const", out_result, 32'd14);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd2, 1'b1);
    chk("remu_const", out_result, 32'd2);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    chk("div_const", out_result, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
    chk("rem_const", out_result, 32'hFFFF_FFFF);
    do_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1);
    chk("mulhsu_const", out_result, 32'hFFFF_FFFF);
    do_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd9, 1'b1);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0, 5'd10, 1'b1);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);

    // Flush during a divide: discard the result and return to idle
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'd13;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    chk("flush_no_valid", {31'd0, rose}, 32'd0);

    // Flush coinciding with a request in idle blocks acceptance
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd2; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_blocked", {31'd0, busy}, 32'd0);

    do_op("mulhu_after_flush", 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd14, 1'b1);
    chk("mulhu_const", out_result, 32'd1);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op("rand", rop, ra, rb, 5'($urandom_range(0, 31)), 1'b1);
    end

    // Backpressure: DONE held with stable outputs, no new accept
    do_op("bp_div", 3'd4, 32'd12345, 32'hFFFF_FFF0, 5'd21, 1'b0);
    held_res = out_result;
    held_tag = out_tag;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd3; in_tag = 5'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, held_res);
      chk("bp_tag", {27'd0, out_tag}, {27'd0, held_tag});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    // Asynchronous reset mid-cycle clears outputs immediately
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    chk("async_rst_tag", {27'd0, out_tag}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_reset_divu", 3'd5, 32'hFFFF_FFFF, 32'd16, 5'd30, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
